// File: rtl/count_pkg.sv
// Shared constants for the up/down counter with parallel load.
package count_pkg;

    localparam int   COUNT_WIDTH_DEFAULT = 4;
    localparam logic DIR_UP              = 1'b1;
    localparam logic DIR_DOWN            = 1'b0;

endpackage : count_pkg

// File: rtl/up_down_count_load.sv
// Synchronous binary up/down counter with parallel load.
module up_down_count_load
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             mod,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Load beats counting; carry and borrow simply fall off the top.
    always_comb begin
        q_d = q_q;
        priority case (1'b1)
            load:             q_d = d;
            (mod == DIR_UP):  q_d = q_q + WIDTH'(1);
            default:          q_d = q_q - WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : up_down_count_load

// File: tb/tb_up_down_count_load.sv
// Scoreboard bench for up_down_count_load: directed plan plus random traffic.
module tb_up_down_count_load;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    typedef struct {
        int    exp;
        string tag;
    } sb_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic         load;
    logic         mod;
    logic [W-1:0] q;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;
    int  model  = 0;

    up_down_count_load #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .load(load),
        .mod (mod),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the rule list applied with plain integer arithmetic.
    function automatic int next_val(int cur, bit r, bit l, bit m, int dv);
        if (r) return 0;
        if (l) return dv;
        if (m) return (cur + 1) % MOD;
        return (cur + MOD - 1) % MOD;
    endfunction

    task automatic drive(bit r, bit l, bit m, int dv, int want, string tag);
        sb_t e;
        @(negedge clk);
        rst  = r;
        load = l;
        mod  = m;
        d    = W'(dv);
        model = next_val(model, r, l, m, dv);
        e.exp = (want < 0) ? model : want;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: the counter produces a new value after every edge.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (q !== W'(e.exp)) begin
                    errors++;
                    $display("FAIL %s: q=%0d expected %0d at %0t",
                             e.tag, q, e.exp, $time);
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b0; load = 1'b0; mod = 1'b1; d = '0;

        drive(1, 0, 1, 0, 0, "reset");
        drive(0, 0, 1, 0, 1, "reset_up1");
        drive(0, 0, 1, 0, 2, "reset_up2");
        drive(0, 0, 1, 0, 3, "reset_up3");

        drive(0, 1, 1, 3, 3, "load_up");
        for (int i = 4; i <= 8; i++) drive(0, 0, 1, 0, i, "count_up");

        drive(0, 1, 0, 7, 7, "load_down");
        for (int i = 6; i >= 4; i--) drive(0, 0, 0, 0, i, "count_down");

        drive(0, 1, 1, 14, 14, "wrap_up_load");
        drive(0, 0, 1, 0, 15, "wrap_up_15");
        drive(0, 0, 1, 0, 0, "wrap_up_0");
        drive(0, 0, 1, 0, 1, "wrap_up_1");
        drive(0, 1, 0, 1, 1, "wrap_dn_load");
        drive(0, 0, 0, 0, 0, "wrap_dn_0");
        drive(0, 0, 0, 0, 15, "wrap_dn_15");
        drive(0, 0, 0, 0, 14, "wrap_dn_14");

        drive(1, 1, 1, 9, 0, "rst_over_load");
        drive(0, 1, 1, 9, 9, "load_hold1");
        drive(0, 1, 0, 9, 9, "load_hold2");
        drive(0, 1, 1, 9, 9, "load_hold3");

        drive(0, 1, 1, 4, 4, "mid_load");
        drive(0, 0, 1, 0, 5, "mid_up");
        drive(0, 0, 0, 0, 4, "mid_flip1");
        drive(0, 0, 0, 0, 3, "mid_flip2");
        drive(1, 0, 0, 0, 0, "mid_rst");
        drive(0, 0, 0, 0, 15, "post_rst_down");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, MOD - 1)),
                  -1, "random");
        end

        @(negedge clk);
        rst = 1'b1; load = 1'b0;
        w = 0;
        while (sb_q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #2;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule : tb_up_down_count_load
